apb_slave_regfile: RTL and testbench
====================================

Name: apb_slave_regfile

Overview:
- APB3 completer (slave) that terminates transfers issued by the bridge's APB master side.
- Holds a bank of NUM_REGS read/write 32-bit registers plus one read-only status word.
- Inserts a programmable number of wait states and flags bad accesses with Pslverr.
- Instantiated behind the AHB2APB bridge as the reference peripheral for bring-up and regression.

Parameters:
- NUM_REGS, 16, number of R/W registers; must be a power of two, 2..256.
- WAIT_CYCLES, 2, access-phase cycles with Pready low before completion; 0..15.
- BASE_ADDR, 32'h0000_0000, byte address of register 0; aligned to (NUM_REGS+1)*4 rounded up to a power of two.
- RESET_VAL, 32'h0000_0000, reset value of every R/W register.

Ports:
- Pclk  input  1  APB clock; all state changes on its rising edge.
- Presetn  input  1  asynchronous active-low reset.
- Psel  input  1  slave select from the APB master.
- Penable  input  1  access-phase indicator.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address.
- Pwdata  input  32  write data.
- status_in  input  32  live status word, readable at offset NUM_REGS*4.
- Pready  output  1  transfer completion, registered.
- Prdata  output  32  read data, registered; valid only while Pready=1.
- Pslverr  output  1  error response, registered; valid only while Pready=1.
- reg_q  output  NUM_REGS*32  flattened register contents; reg i occupies bits [32i+31:32i].

Behaviour:
- Reset (Presetn=0, asynchronous):
  - state=IDLE; Pready=0; Prdata=0; Pslverr=0; wait counter=0.
  - All registers = RESET_VAL; latched address and error = 0.
- Decode, latched on the setup cycle (Psel=1, Penable=0):
  - off = Paddr - BASE_ADDR.
  - err = (Paddr[1:0]!=0) | (Paddr < BASE_ADDR) | (off > NUM_REGS*4) | (Pwrite & off==NUM_REGS*4).
  - index = off[log2(NUM_REGS)+1:2].
- State machine (IDLE, WAIT, READY):
  - IDLE: on a setup cycle, latch index, err and Pwrite. If WAIT_CYCLES==0, go to READY; otherwise go to WAIT with cnt=WAIT_CYCLES. Any other input holds IDLE.
  - WAIT: Pready=0. Each cycle with Psel&Penable, cnt decrements. When cnt==1 at that edge, go to READY. Psel=0 (master abort) returns to IDLE with no side effects.
  - READY: Pready=1. Prdata = reg[index], or status_in sampled at the READY-entry edge, or 0 if err. Pslverr=err.
  - READY exit: at the edge with Psel&Penable&Pready, if Pwrite&!err then reg[index] <= Pwdata. Next state is IDLE; Pready, Pslverr and Prdata clear to 0.
- Timing:
  - The number of access cycles with Pready=0 is exactly WAIT_CYCLES.
  - Total transfer = 2 + WAIT_CYCLES cycles.
  - The written value is visible on reg_q the cycle after the READY cycle.
- Back-to-back transfers: the master's next setup cycle falls in the cycle after READY. IDLE accepts it with no bubble beyond the APB-mandated setup phase.
- Error handling: errored writes change no register. Errored reads return 0.
- Protocol violations:
  - Penable=1 without a prior setup is ignored in IDLE.
  - Paddr, Pwrite or Pwdata changing during WAIT does not alter the latched decode; Pwdata is sampled at the READY-exit edge.
- Reset mid-transfer: immediate return to IDLE; the pending write is discarded and Pready drops asynchronously.

Test Plan:
- Reset, then read offset 0x0 and offset 0x3C (WAIT_CYCLES=2) -> Pready high in the 3rd access cycle; Prdata=0, Pslverr=0.
- Write 0xDEADBEEF to 0x08, then read 0x08 -> reg_q[95:64]=0xDEADBEEF one cycle after READY; read returns 0xDEADBEEF; other registers stay 0.
- status_in=0x1234_5678: read 0x40 -> Prdata=0x12345678, Pslverr=0. Write 0x40 -> Pslverr=1 and no register changes.
- Error cases:
  - Misaligned read 0x06 -> Pslverr=1, Prdata=0.
  - Write to 0x44 -> Pslverr=1, reg_q unchanged.
  - BASE_ADDR=0x1000 with Paddr=0x0FFC -> Pslverr=1.
- WAIT_CYCLES=0: back-to-back write to 0x00 (0xA5) and read from 0x00 -> each transfer takes 2 cycles; Pready high in every access cycle; the read returns 0xA5.
- Abort and reset:
  - Master drops Psel during WAIT of a write to 0x04 (0xFF) -> state returns to IDLE; reg[1] stays 0.
  - Presetn pulsed low during WAIT -> all outputs return to 0 immediately.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB3 completer with a bank of R/W registers and a read-only status word.
// Inserts WAIT_CYCLES wait states and reports bad accesses on Pslverr.
module apb_slave_regfile #(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                     Pclk,
    input  logic                     Presetn,
    input  logic                     Psel,
    input  logic                     Penable,
    input  logic                     Pwrite,
    input  logic [31:0]              Paddr,
    input  logic [31:0]              Pwdata,
    input  logic [31:0]              status_in,
    output logic                     Pready,
    output logic [31:0]              Prdata,
    output logic                     Pslverr,
    output logic [NUM_REGS*32-1:0]   reg_q
);

    localparam int unsigned IdxW      = $clog2(NUM_REGS);
    localparam logic [31:0] StatusOff = 32'(NUM_REGS * 4);
    localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [IdxW-1:0]    idx_q;
    logic               err_q;
    logic               write_q;
    logic               status_q;
    logic [31:0]        regs_q [NUM_REGS];

    logic [31:0]        off;
    logic               dec_err;
    logic               dec_status;
    logic [IdxW-1:0]    dec_idx;
    logic               setup;
    logic               access;

    logic [IdxW-1:0]    rsp_idx;
    logic               rsp_err;
    logic               rsp_status;
    logic [31:0]        rsp_rdata;

    always_comb begin
        off        = Paddr - BASE_ADDR;
        dec_status = (off == StatusOff);
        dec_err    = (Paddr[1:0] != 2'b00) | (Paddr < BASE_ADDR) | (off > StatusOff) |
                     (Pwrite & dec_status);
        dec_idx    = off[IdxW+1:2];
        setup      = Psel & ~Penable;
        access     = Psel & Penable;
    end

    // Zero-wait transfers enter READY straight from the setup edge, before the
    // latched decode exists, so the response is built from the live decode then.
    always_comb begin
        rsp_idx    = idx_q;
        rsp_err    = err_q;
        rsp_status = status_q;
        if (state_q == StIdle) begin
            rsp_idx    = dec_idx;
            rsp_err    = dec_err;
            rsp_status = dec_status;
        end
        if (rsp_err) begin
            rsp_rdata = 32'h0;
        end else if (rsp_status) begin
            rsp_rdata = status_in;
        end else begin
            rsp_rdata = regs_q[rsp_idx];
        end
    end

    always_ff @(posedge Pclk or negedge Presetn) begin
        if (!Presetn) begin
            state_q  <= StIdle;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            err_q    <= 1'b0;
            write_q  <= 1'b0;
            status_q <= 1'b0;
            Pready   <= 1'b0;
            Prdata   <= 32'h0;
            Pslverr  <= 1'b0;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (setup) begin
                        idx_q    <= dec_idx;
                        err_q    <= dec_err;
                        write_q  <= Pwrite;
                        status_q <= dec_status;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StReady;
                            Pready  <= 1'b1;
                            Prdata  <= rsp_rdata;
                            Pslverr <= rsp_err;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WaitInit;
                        end
                    end
                end
                StWait: begin
                    if (!Psel) begin
                        // Master abort: drop the transfer without touching registers.
                        state_q <= StIdle;
                        cnt_q   <= 4'd0;
                    end else if (Penable) begin
                        if (cnt_q == 4'd1) begin
                            state_q <= StReady;
                            cnt_q   <= 4'd0;
                            Pready  <= 1'b1;
                            Prdata  <= rsp_rdata;
                            Pslverr <= rsp_err;
                        end else begin
                            cnt_q <= cnt_q - 4'd1;
                        end
                    end
                end
                StReady: begin
                    if (access && Pready) begin
                        if (write_q && !err_q) begin
                            regs_q[idx_q] <= Pwdata;
                        end
                        state_q <= StIdle;
                        Pready  <= 1'b0;
                        Prdata  <= 32'h0;
                        Pslverr <= 1'b0;
                    end else if (!Psel) begin
                        state_q <= StIdle;
                        Pready  <= 1'b0;
                        Prdata  <= 32'h0;
                        Pslverr <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_flat
        assign reg_q[32*i +: 32] = regs_q[i];
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Randomized bench for apb_slave_regfile: three instances (2 waits, 0 waits,
// 3 waits at base 0x1000) checked against an address-map reference model.
module tb_apb_slave_regfile;

    logic         Pclk;
    logic         Presetn;
    logic [2:0]   psel;
    logic         Penable;
    logic         Pwrite;
    logic [31:0]  Paddr;
    logic [31:0]  Pwdata;
    logic [31:0]  status_in;

    logic         pready_w  [3];
    logic [31:0]  prdata_w  [3];
    logic         pslverr_w [3];
    logic [511:0] regq_w    [3];

    int unsigned  wait_cfg [3] = '{2, 0, 3};
    logic [31:0]  base_cfg [3] = '{32'h0, 32'h0, 32'h1000};

    logic [31:0]  mdl [3][16];
    int           n_vec;
    int           n_err;

    initial Pclk = 1'b0;
    always #5 Pclk = ~Pclk;

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(2), .BASE_ADDR(32'h0),
                        .RESET_VAL(32'h0)) u_dut_w2 (
        .Pclk(Pclk), .Presetn(Presetn), .Psel(psel[0]), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .status_in(status_in), .Pready(pready_w[0]),
        .Prdata(prdata_w[0]), .Pslverr(pslverr_w[0]), .reg_q(regq_w[0]));

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(0), .BASE_ADDR(32'h0),
                        .RESET_VAL(32'h0)) u_dut_w0 (
        .Pclk(Pclk), .Presetn(Presetn), .Psel(psel[1]), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .status_in(status_in), .Pready(pready_w[1]),
        .Prdata(prdata_w[1]), .Pslverr(pslverr_w[1]), .reg_q(regq_w[1]));

    apb_slave_regfile #(.NUM_REGS(16), .WAIT_CYCLES(3), .BASE_ADDR(32'h1000),
                        .RESET_VAL(32'h0)) u_dut_b1k (
        .Pclk(Pclk), .Presetn(Presetn), .Psel(psel[2]), .Penable(Penable), .Pwrite(Pwrite),
        .Paddr(Paddr), .Pwdata(Pwdata), .status_in(status_in), .Pready(pready_w[2]),
        .Prdata(prdata_w[2]), .Pslverr(pslverr_w[2]), .reg_q(regq_w[2]));

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] model_vec(input int k);
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = mdl[k][i];
        return v;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 16; i++) mdl[k][i] = 32'h0;
    endtask

    // Address map: 16 words of R/W storage, then one read-only status word.
    task automatic model_xfer(input int k, input logic wr, input logic [31:0] addr,
                              input logic [31:0] data, output logic err,
                              output logic [31:0] rd);
        logic [31:0] off;
        int          idx;
        off = addr - base_cfg[k];
        err = (addr % 4 != 0) || (addr < base_cfg[k]) || (off > 64) || (wr && off == 64);
        rd  = 32'h0;
        if (!err) begin
            if (off == 64) begin
                rd = status_in;
            end else begin
                idx = int'(off / 4);
                rd  = mdl[k][idx];
                if (wr) mdl[k][idx] = data;
            end
        end
    endtask

    // Called at posedge+1; drives the setup phase immediately so calls chain back-to-back.
    task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, input bit scramble);
        logic        exp_err;
        logic [31:0] exp_rd;
        int          lows;
        model_xfer(k, wr, addr, data, exp_err, exp_rd);
        psel    = 3'b000;
        psel[k] = 1'b1;
        Penable = 1'b0;
        Pwrite  = wr;
        Paddr   = addr;
        Pwdata  = data;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        lows = 0;
        while (!pready_w[k] && lows < 40) begin
            lows++;
            if (scramble) begin
                Paddr  = $urandom;
                Pwrite = 1'($urandom);
                Pwdata = $urandom;
            end
            @(posedge Pclk); #1;
        end
        Paddr  = addr;
        Pwrite = wr;
        Pwdata = data;
        check($sformatf("wait_cycles[%0d]", k), 512'(lows), 512'(wait_cfg[k]));
        if (pready_w[k]) begin
            check($sformatf("pslverr[%0d] @%0h", k, addr), 512'(pslverr_w[k]), 512'(exp_err));
            if (!wr) check($sformatf("prdata[%0d] @%0h", k, addr), 512'(prdata_w[k]),
                           512'(exp_rd));
            @(posedge Pclk); #1;
            check("pready_clear", 512'(pready_w[k]), 512'(0));
            check("prdata_clear", 512'(prdata_w[k]), 512'(0));
            check($sformatf("reg_q[%0d]", k), regq_w[k], model_vec(k));
        end
        psel    = 3'b000;
        Penable = 1'b0;
    endtask

    task automatic reset_mid(input int k, input bit in_ready);
        int guard;
        psel    = 3'b000;
        psel[k] = 1'b1;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = base_cfg[k] + 32'h4;
        Pwdata  = 32'hFFFF_FFFF;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        guard = 0;
        while (in_ready && !pready_w[k] && guard < 40) begin
            guard++;
            @(posedge Pclk); #1;
        end
        if (in_ready) check("ready_before_reset", 512'(pready_w[k]), 512'(1));
        #2 Presetn = 1'b0;
        #1;
        model_clear();
        for (int j = 0; j < 3; j++) begin
            check($sformatf("rst_pready[%0d]", j), 512'(pready_w[j]), 512'(0));
            check($sformatf("rst_prdata[%0d]", j), 512'(prdata_w[j]), 512'(0));
            check($sformatf("rst_pslverr[%0d]", j), 512'(pslverr_w[j]), 512'(0));
            check($sformatf("rst_reg_q[%0d]", j), regq_w[j], model_vec(j));
        end
        psel    = 3'b000;
        Penable = 1'b0;
        @(posedge Pclk); #1;
        Presetn = 1'b1;
    endtask

    task automatic random_xfers(input int n);
        int          k;
        int          r;
        int          gap;
        logic [31:0] b;
        logic [31:0] a;
        for (int t = 0; t < n; t++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(posedge Pclk); #1;
            end
            k = int'($urandom_range(0, 2));
            b = base_cfg[k];
            r = int'($urandom_range(0, 9));
            if (r <= 5)      a = b + 4 * $urandom_range(0, 15);
            else if (r == 6) a = b + 32'd64;
            else if (r == 7) a = b + 32'd64 + 4 * $urandom_range(1, 8);
            else if (r == 8) a = b + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            else             a = b - 4 * $urandom_range(1, 4);
            status_in = $urandom;
            xfer(k, 1'($urandom), a, $urandom, 1'b1);
        end
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        psel      = 3'b000;
        Penable   = 1'b0;
        Pwrite    = 1'b0;
        Paddr     = 32'h0;
        Pwdata    = 32'h0;
        status_in = 32'h0;
        model_clear();
        Presetn   = 1'b1;
        #2 Presetn = 1'b0;
        repeat (2) @(posedge Pclk);
        #1 Presetn = 1'b1;
        for (int j = 0; j < 3; j++) begin
            check($sformatf("init_pready[%0d]", j), 512'(pready_w[j]), 512'(0));
            check($sformatf("init_prdata[%0d]", j), 512'(prdata_w[j]), 512'(0));
            check($sformatf("init_pslverr[%0d]", j), 512'(pslverr_w[j]), 512'(0));
            check($sformatf("init_reg_q[%0d]", j), regq_w[j], model_vec(j));
        end

        status_in = 32'h1234_5678;
        xfer(0, 1'b0, 32'h00, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h3C, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h08, 32'hDEAD_BEEF, 1'b0);
        check("reg2_slice", 512'(regq_w[0][95:64]), 512'(32'hDEAD_BEEF));
        xfer(0, 1'b0, 32'h08, 32'h0, 1'b0);
        xfer(0, 1'b0, 32'h40, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h40, 32'h5555_5555, 1'b0);
        xfer(0, 1'b0, 32'h06, 32'h0, 1'b0);
        xfer(0, 1'b1, 32'h44, 32'h7777_7777, 1'b0);
        xfer(2, 1'b0, 32'h0FFC, 32'h0, 1'b0);
        xfer(2, 1'b0, 32'h1040, 32'h0, 1'b0);

        // Zero-wait instance, back-to-back write then read.
        xfer(1, 1'b1, 32'h00, 32'h0000_00A5, 1'b0);
        xfer(1, 1'b0, 32'h00, 32'h0, 1'b0);

        // Master abort during the wait phase of a write.
        psel    = 3'b001;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h04;
        Pwdata  = 32'h0000_00FF;
        @(posedge Pclk); #1;
        Penable = 1'b1;
        @(posedge Pclk); #1;
        psel    = 3'b000;
        Penable = 1'b0;
        @(posedge Pclk); #1;
        check("abort_pready", 512'(pready_w[0]), 512'(0));
        check("abort_reg_q", regq_w[0], model_vec(0));
        xfer(0, 1'b0, 32'h04, 32'h0, 1'b0);

        // Penable without a preceding setup phase must be ignored.
        psel    = 3'b001;
        Penable = 1'b1;
        Pwrite  = 1'b1;
        Paddr   = 32'h0C;
        Pwdata  = 32'h1111_1111;
        for (int c = 0; c < 3; c++) begin
            @(posedge Pclk); #1;
            check("no_setup_pready", 512'(pready_w[0]), 512'(0));
        end
        psel    = 3'b000;
        Penable = 1'b0;
        @(posedge Pclk); #1;
        check("no_setup_reg_q", regq_w[0], model_vec(0));

        random_xfers(150);
        reset_mid(0, 1'b0);
        random_xfers(100);
        reset_mid(2, 1'b1);
        random_xfers(100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
